// File: rtl/denise_collision_unit_pkg.sv
// Shared constants and combinational match logic for the Denise collision unit.
package denise_collision_unit_pkg;

    // Register word addresses; only bits [8:1] are decoded.
    localparam logic [8:0] CLXDAT_ADDR  = 9'h00E;
    localparam logic [8:0] CLXCON_ADDR  = 9'h098;
    localparam logic [8:0] CLXCON2_ADDR = 9'h10E;

    // CLXCON field positions (ENSP7,5,3,1 / ENBP6..1 / MVBP6..1).
    localparam int unsigned ENSP_LSB = 12;
    localparam int unsigned ENBP_LSB = 6;
    localparam int unsigned MVBP_LSB = 0;

    // CLXCON2 field positions (ENBP8,7 / MVBP8,7).
    localparam int unsigned ENBP78_LSB = 6;
    localparam int unsigned MVBP78_LSB = 0;

    // CLXDAT bit positions.
    localparam int unsigned CLX_EVEN_ODD = 0;
    localparam int unsigned CLX_ODD_SP   = 1;
    localparam int unsigned CLX_EVEN_SP  = 5;
    localparam int unsigned CLX_SP01     = 9;
    localparam int unsigned CLX_SP02     = 10;
    localparam int unsigned CLX_SP03     = 11;
    localparam int unsigned CLX_SP12     = 12;
    localparam int unsigned CLX_SP13     = 13;
    localparam int unsigned CLX_SP23     = 14;

    typedef struct packed {
        logic [1:0] enbp;   // {ENBP8, ENBP7}
        logic [1:0] mvbp;   // {MVBP8, MVBP7}
    } clxcon2_t;

    function automatic logic [14:0] collision_events(
        input logic [15:0] clxcon,
        input clxcon2_t    clxcon2,
        input logic        aga,
        input logic        dblpf,
        input logic [8:1]  bpldata,
        input logic [7:0]  nsprite
    );
        logic [8:1]  enbp;
        logic [8:1]  mvbp;
        logic [8:1]  match;
        logic        odd_m;
        logic        even_m;
        logic        odd;
        logic        even;
        logic [3:0]  ensp;
        logic [3:0]  grp;
        logic [14:0] ev;

        // Masking the enables without AGA makes planes 7/8 unconditionally match.
        enbp  = {(aga ? clxcon2.enbp : 2'b00), clxcon[ENBP_LSB +: 6]};
        mvbp  = {clxcon2.mvbp, clxcon[MVBP_LSB +: 6]};
        match = ~enbp | ~(bpldata ^ mvbp);

        odd_m  = match[1] & match[3] & match[5] & match[7];
        even_m = match[2] & match[4] & match[6] & match[8];
        odd    = dblpf ? odd_m  : (odd_m & even_m);
        even   = dblpf ? even_m : (odd_m & even_m);

        ensp   = clxcon[ENSP_LSB +: 4];
        grp[0] = nsprite[0] | (nsprite[1] & ensp[0]);
        grp[1] = nsprite[2] | (nsprite[3] & ensp[1]);
        grp[2] = nsprite[4] | (nsprite[5] & ensp[2]);
        grp[3] = nsprite[6] | (nsprite[7] & ensp[3]);

        ev                   = '0;
        ev[CLX_EVEN_ODD]     = even & odd;
        ev[CLX_ODD_SP +: 4]  = {4{odd}} & grp;
        ev[CLX_EVEN_SP +: 4] = {4{even}} & grp;
        ev[CLX_SP01]         = grp[0] & grp[1];
        ev[CLX_SP02]         = grp[0] & grp[2];
        ev[CLX_SP03]         = grp[0] & grp[3];
        ev[CLX_SP12]         = grp[1] & grp[2];
        ev[CLX_SP13]         = grp[1] & grp[3];
        ev[CLX_SP23]         = grp[2] & grp[3];
        return ev;
    endfunction

endpackage

// File: rtl/denise_collision_unit.sv
// Denise collision detector: per-pixel bitplane/sprite overlap checks accumulated
// into sticky CLXDAT flags, read (and cleared) over the register bus.
module denise_collision_unit
    import denise_collision_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        aga,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        dblpf,
    input  logic [8:1]  bpldata,
    input  logic [7:0]  nsprite
);

    logic [15:0] clxcon_q;
    clxcon2_t    clxcon2_q;
    logic [14:0] clxdat_q;
    logic [14:0] clxdat_d;
    logic [14:0] events;
    logic        sel_clxdat;
    logic        sel_clxcon;
    logic        sel_clxcon2;
    logic        read_clear;

    assign sel_clxdat  = (reg_address_in == CLXDAT_ADDR[8:1]);
    assign sel_clxcon  = (reg_address_in == CLXCON_ADDR[8:1]);
    assign sel_clxcon2 = (reg_address_in == CLXCON2_ADDR[8:1]);
    assign read_clear  = clk7_en & sel_clxdat;

    always_comb begin
        events = collision_events(clxcon_q, clxcon2_q, aga, dblpf, bpldata, nsprite);
        // New events are OR-ed after the clear so a hit in the read cycle survives.
        clxdat_d = (read_clear ? 15'd0 : clxdat_q) | events;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clxcon_q  <= '0;
            clxcon2_q <= '0;
            clxdat_q  <= '0;
        end else begin
            clxdat_q <= clxdat_d;
            if (clk7_en) begin
                if (sel_clxcon) begin
                    clxcon_q  <= data_in;
                    clxcon2_q <= '0;
                end else if (sel_clxcon2 && aga) begin
                    clxcon2_q.enbp <= data_in[ENBP78_LSB +: 2];
                    clxcon2_q.mvbp <= data_in[MVBP78_LSB +: 2];
                end
            end
        end
    end

    always_comb begin
        data_out = 16'h0000;
        if (sel_clxdat) begin
            data_out = {1'b1, clxdat_q};
        end
    end

endmodule

// File: tb/tb_denise_collision_unit.sv
// Directed plus randomised bench for denise_collision_unit with a queue scoreboard.
module tb_denise_collision_unit;

    localparam logic [8:1] A_CLXDAT  = 8'h07;
    localparam logic [8:1] A_CLXCON  = 8'h4C;
    localparam logic [8:1] A_CLXCON2 = 8'h87;
    localparam logic [8:1] A_IDLE    = 8'h00;

    logic        clk;
    logic        reset;
    logic        clk7_en;
    logic        aga;
    logic [8:1]  reg_address_in;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        dblpf;
    logic [8:1]  bpldata;
    logic [7:0]  nsprite;

    int vectors;
    int miscompares;
    logic [15:0] exp_q[$];

    // Reference state
    logic [15:0] m_clxcon;
    logic [7:0]  m_clxcon2;
    logic [14:0] m_clxdat;

    denise_collision_unit dut (
        .clk            (clk),
        .reset          (reset),
        .clk7_en        (clk7_en),
        .aga            (aga),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .data_out       (data_out),
        .dblpf          (dblpf),
        .bpldata        (bpldata),
        .nsprite        (nsprite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] model_events(input logic [15:0] cc, input logic [7:0] c2,
                                                 input logic ag, input logic dp,
                                                 input logic [8:1] bp, input logic [7:0] ns);
        logic odd_ok, even_ok, o, e, en, mv;
        logic [3:0] g;
        logic [14:0] ev;
        int k;
        odd_ok  = 1'b1;
        even_ok = 1'b1;
        for (int p = 1; p <= 8; p++) begin
            if (p <= 6) begin
                en = cc[5 + p];
                mv = cc[p - 1];
            end else begin
                en = ag & c2[p - 1];
                mv = c2[p - 7];
            end
            if (en && (bp[p] != mv)) begin
                if (p % 2 == 1) odd_ok = 1'b0;
                else            even_ok = 1'b0;
            end
        end
        o = dp ? odd_ok  : (odd_ok & even_ok);
        e = dp ? even_ok : (odd_ok & even_ok);
        for (int i = 0; i < 4; i++) g[i] = ns[2 * i] | (ns[2 * i + 1] & cc[12 + i]);
        ev    = '0;
        ev[0] = o & e;
        for (int i = 0; i < 4; i++) begin
            ev[1 + i] = o & g[i];
            ev[5 + i] = e & g[i];
        end
        k = 9;
        for (int a = 0; a < 3; a++) begin
            for (int b = a + 1; b < 4; b++) begin
                ev[k] = g[a] & g[b];
                k++;
            end
        end
        return ev;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_clxcon  <= '0;
            m_clxcon2 <= '0;
            m_clxdat  <= '0;
        end else begin
            m_clxdat <= ((clk7_en && reg_address_in == A_CLXDAT) ? 15'd0 : m_clxdat)
                        | model_events(m_clxcon, m_clxcon2, aga, dblpf, bpldata, nsprite);
            if (clk7_en && reg_address_in == A_CLXCON) begin
                m_clxcon  <= data_in;
                m_clxcon2 <= '0;
            end else if (clk7_en && reg_address_in == A_CLXCON2 && aga) begin
                m_clxcon2 <= data_in[7:0];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string tag, input logic [15:0] exp);
        logic [15:0] got;
        logic [15:0] want;
        exp_q.push_back(exp);
        #4;
        got  = data_out;
        want = exp_q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: data_out=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic write_reg(input logic [8:1] addr, input logic [15:0] d);
        reg_address_in = addr;
        data_in        = d;
        clk7_en        = 1'b1;
        tick();
        clk7_en        = 1'b0;
        reg_address_in = A_IDLE;
        data_in        = '0;
    endtask

    task automatic read_chk(input string tag, input logic clr, input logic [15:0] exp);
        reg_address_in = A_CLXDAT;
        clk7_en        = clr;
        sb_check(tag, exp);
        tick();
        clk7_en        = 1'b0;
        reg_address_in = A_IDLE;
    endtask

    initial begin
        int r;
        logic [15:0] exp;
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        clk7_en        = 1'b0;
        aga            = 1'b0;
        reg_address_in = A_IDLE;
        data_in        = '0;
        dblpf          = 1'b0;
        bpldata        = '0;
        nsprite        = '0;

        #2;
        reg_address_in = A_CLXDAT;
        sb_check("reset_read", 16'h8000);
        reg_address_in = A_IDLE;
        sb_check("idle_read", 16'h0000);
        tick();
        reset = 1'b0;

        // Bit 0 accumulates while nothing is enabled; clear it once plane 1 is enabled.
        dblpf = 1'b1;
        write_reg(A_CLXCON, 16'h0041);
        read_chk("clear_initial", 1'b1, 16'h8001);
        read_chk("after_clear", 1'b0, 16'h8000);

        bpldata = 8'h01; nsprite = 8'h01;
        tick();
        bpldata = 8'h00; nsprite = 8'h00;
        read_chk("odd_even_g0_keep", 1'b0, 16'h8023);
        read_chk("odd_even_g0_clr", 1'b1, 16'h8023);
        read_chk("cleared", 1'b0, 16'h8000);

        bpldata = 8'h01; nsprite = 8'h02;
        tick();
        bpldata = 8'h00; nsprite = 8'h00;
        read_chk("ensp1_off", 1'b1, 16'h8001);

        dblpf = 1'b0;
        write_reg(A_CLXCON, 16'h1041);
        nsprite = 8'h06;
        tick();
        nsprite = 8'h00;
        read_chk("sprite_pair", 1'b1, 16'h8200);

        write_reg(A_CLXCON, 16'h0FC0);
        nsprite = 8'h01;
        tick();
        nsprite = 8'h00;
        read_chk("combined_match", 1'b1, 16'h8023);
        bpldata = 8'h02; nsprite = 8'h01;
        tick();
        read_chk("plane2_block", 1'b1, 16'h8001);
        read_chk("no_bpl_events", 1'b0, 16'h8000);
        nsprite = 8'h00;

        aga = 1'b0;
        write_reg(A_CLXCON2, 16'h0040);
        bpldata = 8'h40;
        tick();
        bpldata = 8'h02;
        read_chk("aga0_p7_dontcare", 1'b1, 16'h8001);
        aga = 1'b1;
        write_reg(A_CLXCON2, 16'h0040);
        bpldata = 8'h40;
        tick();
        read_chk("aga1_p7_block", 1'b1, 16'h8000);
        write_reg(A_CLXCON, 16'h0FC0);
        tick();
        bpldata = 8'h02;
        read_chk("clxcon2_cleared", 1'b1, 16'h8001);

        nsprite = 8'h14;
        tick();
        nsprite = 8'h00;
        sb_check("unaddressed_nonzero", 16'h0000);
        bpldata = 8'h00;
        read_chk("rdclr_set_wins", 1'b1, 16'h9000);
        bpldata = 8'h02;
        read_chk("new_bit_kept", 1'b0, 16'h8001);
        read_chk("no_clr_en_low", 1'b0, 16'h8001);

        nsprite = 8'h14;
        tick();
        reset = 1'b1;
        reg_address_in = A_CLXDAT;
        nsprite = 8'h00;
        sb_check("reset_midline", 16'h8000);
        tick();
        reset = 1'b0;
        reg_address_in = A_IDLE;
        read_chk("post_reset", 1'b0, 16'h8000);

        // Randomised traffic checked against the reference model every cycle.
        for (int n = 0; n < 400; n++) begin
            bpldata = 8'($urandom);
            nsprite = 8'($urandom) & 8'($urandom);
            dblpf   = 1'($urandom);
            aga     = 1'($urandom);
            data_in = 16'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                0, 1: begin reg_address_in = A_CLXDAT;  clk7_en = 1'b1; end
                2:    begin reg_address_in = A_CLXDAT;  clk7_en = 1'b0; end
                3:    begin reg_address_in = A_CLXCON;  clk7_en = 1'b1; end
                4:    begin reg_address_in = A_CLXCON2; clk7_en = 1'b1; end
                default: begin reg_address_in = A_IDLE; clk7_en = 1'($urandom); end
            endcase
            exp = (reg_address_in == A_CLXDAT) ? {1'b1, m_clxdat} : 16'h0000;
            sb_check("random", exp);
            tick();
        end
        clk7_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
